// File: rtl/frame_buffer_banked.sv
// Banked frame store: streamed pixel writes, random-access reads, bank swap at frame boundaries.
// Define FRAME_BUFFER_OUTPUT_REG_EN to add an output register after the RAM read (2-cycle read latency).
module frame_buffer_banked #(
    parameter int WIDTH     = 12,
    parameter int DEPTH     = 76800,
    parameter int NUM_BANKS = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         wr_valid_i,
    input  logic                         wr_sof_i,
    input  logic [WIDTH-1:0]             wr_data_i,
    output logic                         wr_ready_o,
    input  logic                         rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]     rd_addr_i,
    input  logic                         rd_sof_i,
    output logic [WIDTH-1:0]             rd_data_o,
    output logic                         frame_ready_o,
    output logic [$clog2(NUM_BANKS)-1:0] rd_bank_o,
    output logic [15:0]                  frames_dropped_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int TOTAL = NUM_BANKS * DEPTH;
    localparam int PAW   = $clog2(TOTAL);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {WR_ACTIVE, WR_WAIT} wr_state_t;

    wr_state_t        state;
    wr_state_t        state_next;
    logic [WIDTH-1:0] mem [TOTAL];
    logic [BW-1:0]    wr_bank;
    logic [BW-1:0]    rd_bank;
    logic [BW-1:0]    latest_bank;
    logic [BW-1:0]    rd_bank_next;
    logic [BW-1:0]    wr_bank_next;
    logic             ready;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    wr_offset;
    logic             wr_fire;
    logic             commit;
    logic             swap;
    logic [PAW-1:0]   wr_phys;
    logic [PAW-1:0]   rd_phys;

    // An SOF pixel always lands at offset 0, abandoning any partial frame in the same bank.
    assign wr_fire      = wr_valid_i & wr_ready_o;
    assign wr_offset    = wr_sof_i ? '0 : wr_addr;
    assign commit       = wr_fire && (wr_offset == LAST_ADDR);
    assign swap         = rd_sof_i & ready;
    assign rd_bank_next = swap ? latest_bank : rd_bank;
    assign wr_phys      = PAW'(wr_bank) * PAW'(DEPTH) + PAW'(wr_offset);
    assign rd_phys      = PAW'(rd_bank) * PAW'(DEPTH) + PAW'(rd_addr_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= WR_ACTIVE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WR_ACTIVE: if (commit && NUM_BANKS == 2) state_next = WR_WAIT;
            WR_WAIT:   if (rd_sof_i) state_next = WR_ACTIVE;
            default:   state_next = WR_ACTIVE;
        endcase
    end

    assign wr_ready_o = (state == WR_ACTIVE);

    // Triple buffer: banks are 0..2, so the free bank is 3 minus the other two.
    always_comb begin
        wr_bank_next = wr_bank;
        if (NUM_BANKS == 2) begin
            if (state == WR_WAIT && rd_sof_i) wr_bank_next = rd_bank;
        end else if (commit) begin
            wr_bank_next = BW'(3) - rd_bank_next - wr_bank;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_bank          <= '0;
            rd_bank          <= BW'(NUM_BANKS - 1);
            latest_bank      <= '0;
            ready            <= 1'b0;
            wr_addr          <= '0;
            frames_dropped_o <= '0;
        end else begin
            wr_bank <= wr_bank_next;
            rd_bank <= rd_bank_next;
            if (wr_fire) begin
                wr_addr <= commit ? '0 : wr_offset + AW'(1);
            end
            if (commit) begin
                latest_bank <= wr_bank;
                ready       <= 1'b1;
                if (ready && !swap && frames_dropped_o != 16'hFFFF) begin
                    frames_dropped_o <= frames_dropped_o + 16'd1;
                end
            end else if (swap) begin
                ready <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire && !reset_i) begin
            mem[wr_phys] <= wr_data_i;
        end
    end

`ifdef FRAME_BUFFER_OUTPUT_REG_EN
    logic [WIDTH-1:0] ram_q;
    logic             rd_en_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ram_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_data_o <= '0;
        end else begin
            rd_en_q <= rd_en_i;
            if (rd_en_i) ram_q <= mem[rd_phys];
            if (rd_en_q) rd_data_o <= ram_q;
        end
    end
`else
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_o <= '0;
        end else if (rd_en_i) begin
            rd_data_o <= mem[rd_phys];
        end
    end
`endif

    assign frame_ready_o = ready;
    assign rd_bank_o     = rd_bank;

endmodule

// File: tb/tb_frame_buffer_banked.sv
// Bench for frame_buffer_banked: a double-buffer and a triple-buffer instance against a frame-level model.
module tb_frame_buffer_banked;
    localparam int WIDTH = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef FRAME_BUFFER_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_valid [2];
    logic             wr_sof [2];
    logic [WIDTH-1:0] wr_data [2];
    logic             rd_en [2];
    logic [AW-1:0]    rd_addr [2];
    logic             rd_sof [2];
    logic             wr_ready [2];
    logic [WIDTH-1:0] rd_data [2];
    logic             frame_ready [2];
    logic [15:0]      dropped [2];
    logic [0:0]       rd_bank_a;
    logic [1:0]       rd_bank_b;

    int compared   = 0;
    int mismatched = 0;

    // Frame-level model: the writer collects pixels, a completed frame becomes "pending",
    // the reader swaps the pending frame in. Index 0 is the double buffer, 1 the triple buffer.
    int nb [2] = '{2, 3};
    int wr_buf [2][DEPTH];
    int wr_cnt [2];
    int pend [2][DEPTH];
    bit pend_valid [2];
    int pend_bank [2];
    int cur [2][DEPTH];
    bit cur_valid [2];
    int m_rd_bank [2];
    int m_wr_bank [2];
    bit waiting [2];
    int m_dropped [2];
    int exp_q0 [$];
    int exp_q1 [$];

    always #5 clk = ~clk;

    frame_buffer_banked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BANKS(2)) dut_a (
        .clk_i(clk), .reset_i(reset),
        .wr_valid_i(wr_valid[0]), .wr_sof_i(wr_sof[0]), .wr_data_i(wr_data[0]), .wr_ready_o(wr_ready[0]),
        .rd_en_i(rd_en[0]), .rd_addr_i(rd_addr[0]), .rd_sof_i(rd_sof[0]), .rd_data_o(rd_data[0]),
        .frame_ready_o(frame_ready[0]), .rd_bank_o(rd_bank_a), .frames_dropped_o(dropped[0])
    );

    frame_buffer_banked #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_BANKS(3)) dut_b (
        .clk_i(clk), .reset_i(reset),
        .wr_valid_i(wr_valid[1]), .wr_sof_i(wr_sof[1]), .wr_data_i(wr_data[1]), .wr_ready_o(wr_ready[1]),
        .rd_en_i(rd_en[1]), .rd_addr_i(rd_addr[1]), .rd_sof_i(rd_sof[1]), .rd_data_o(rd_data[1]),
        .frame_ready_o(frame_ready[1]), .rd_bank_o(rd_bank_b), .frames_dropped_o(dropped[1])
    );

    task automatic checkOutput(string name, int d, longint actual, longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, d, actual, expected);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            wr_cnt[d]     = 0;
            pend_valid[d] = 0;
            pend_bank[d]  = 0;
            cur_valid[d]  = 0;
            m_rd_bank[d]  = nb[d] - 1;
            m_wr_bank[d]  = 0;
            waiting[d]    = 0;
            m_dropped[d]  = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    // Swap sees the pre-commit pending frame; the commit lands afterwards.
    task automatic model_step(int d, bit v, bit sof, int data, bit ren, int addr, bit rsof);
        bit commit_now;
        int old_rd;
        commit_now = 0;
        old_rd     = m_rd_bank[d];
        if (ren) begin
            if (d == 0) exp_q0.push_back(cur[d][addr]);
            else        exp_q1.push_back(cur[d][addr]);
        end
        if (v && !waiting[d]) begin
            if (sof) wr_cnt[d] = 0;
            wr_buf[d][wr_cnt[d]] = data & 'hFFF;
            wr_cnt[d]++;
            if (wr_cnt[d] == DEPTH) begin
                commit_now = 1;
                wr_cnt[d]  = 0;
            end
        end
        if (rsof && pend_valid[d]) begin
            for (int i = 0; i < DEPTH; i++) cur[d][i] = pend[d][i];
            cur_valid[d]  = 1;
            m_rd_bank[d]  = pend_bank[d];
            pend_valid[d] = 0;
        end
        if (waiting[d] && rsof) begin
            waiting[d]   = 0;
            m_wr_bank[d] = old_rd;
        end
        if (commit_now) begin
            if (pend_valid[d] && m_dropped[d] < 65535) m_dropped[d]++;
            for (int i = 0; i < DEPTH; i++) pend[d][i] = wr_buf[d][i];
            pend_valid[d] = 1;
            pend_bank[d]  = m_wr_bank[d];
            if (nb[d] == 3) m_wr_bank[d] = 3 - m_rd_bank[d] - pend_bank[d];
            else            waiting[d] = 1;
        end
    endtask

    task automatic applyStimulus(int d, bit v, bit sof, int data, bit ren, int addr, bit rsof);
        wr_valid[d] = v;
        wr_sof[d]   = sof;
        wr_data[d]  = WIDTH'(data);
        rd_en[d]    = ren;
        rd_addr[d]  = AW'(addr);
        rd_sof[d]   = rsof;
        model_step(d, v, sof, data, ren, addr, rsof);
        @(posedge clk);
        @(negedge clk);
        wr_valid[d] = 1'b0;
        wr_sof[d]   = 1'b0;
        rd_en[d]    = 1'b0;
        rd_sof[d]   = 1'b0;
    endtask

    task automatic checkStatus(int d);
        checkOutput("frame_ready", d, frame_ready[d], pend_valid[d]);
        checkOutput("wr_ready", d, wr_ready[d], waiting[d] ? 0 : 1);
        checkOutput("rd_bank", d, (d == 0) ? rd_bank_a : rd_bank_b, m_rd_bank[d]);
        checkOutput("frames_dropped", d, dropped[d], m_dropped[d]);
    endtask

    task automatic checkReset();
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_wr_ready", d, wr_ready[d], 1);
            checkOutput("rst_frame_ready", d, frame_ready[d], 0);
            checkOutput("rst_rd_bank", d, (d == 0) ? rd_bank_a : rd_bank_b, nb[d] - 1);
            checkOutput("rst_rd_data", d, rd_data[d], 0);
            checkOutput("rst_dropped", d, dropped[d], 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic writeFrame(int d, int base, bit last_rsof);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(d, 1, i == 0, base + i, 0, 0, last_rsof && i == DEPTH - 1);
            checkStatus(d);
        end
    endtask

    task automatic runRandom(int d, int cycles);
        bit v, s, re, rs;
        int data, addr;
        for (int c = 0; c < cycles; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            s    = ($urandom_range(0, 15) == 0);
            re   = cur_valid[d] && ($urandom_range(0, 1) == 1);
            rs   = ($urandom_range(0, 5) == 0);
            data = int'($urandom_range(0, 4095));
            addr = int'($urandom_range(0, DEPTH - 1));
            applyStimulus(d, v, s, data, re, addr, rs);
            checkStatus(d);
        end
    endtask

    // Monitor: pops the scoreboard whenever a read result is due, otherwise checks rd_data holds.
    initial begin : monitor
        logic [1:0] pipe0, pipe1;
        int last0, last1, e;
        pipe0 = '0;
        pipe1 = '0;
        last0 = 0;
        last1 = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pipe0 = '0;
                pipe1 = '0;
                last0 = 0;
                last1 = 0;
            end else begin
                pipe0 = {pipe0[0], rd_en[0]};
                pipe1 = {pipe1[0], rd_en[1]};
                if (pipe0[LAT-1]) begin
                    if (exp_q0.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL rd_data dut0: got 0x%0h, expected no output", rd_data[0]);
                    end else begin
                        e = exp_q0.pop_front();
                        checkOutput("rd_data", 0, rd_data[0], e);
                        last0 = e;
                    end
                end else begin
                    checkOutput("rd_data_hold", 0, rd_data[0], last0);
                end
                if (pipe1[LAT-1]) begin
                    if (exp_q1.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL rd_data dut1: got 0x%0h, expected no output", rd_data[1]);
                    end else begin
                        e = exp_q1.pop_front();
                        checkOutput("rd_data", 1, rd_data[1], e);
                        last1 = e;
                    end
                end else begin
                    checkOutput("rd_data_hold", 1, rd_data[1], last1);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int saved_drops;
        for (int d = 0; d < 2; d++) begin
            wr_valid[d] = 1'b0;
            wr_sof[d]   = 1'b0;
            wr_data[d]  = '0;
            rd_en[d]    = 1'b0;
            rd_addr[d]  = '0;
            rd_sof[d]   = 1'b0;
        end
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkReset();

        // Double buffer: commit stalls the writer until the reader swaps.
        writeFrame(0, 'h100, 0);
        checkOutput("plan_frame_ready", 0, frame_ready[0], 1);
        checkOutput("plan_wr_stall", 0, wr_ready[0], 0);
        applyStimulus(0, 1, 0, 'h1FF, 0, 0, 0);
        checkStatus(0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("plan_rd_bank", 0, rd_bank_a, 0);
        checkOutput("plan_wr_resume", 0, wr_ready[0], 1);
        applyStimulus(0, 0, 0, 0, 1, 3, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 0);
        writeFrame(0, 'h110, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 1);
        checkStatus(0);
        applyStimulus(0, 0, 0, 0, 1, 7, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Triple buffer: three unread frames, two dropped, writer never stalls.
        writeFrame(1, 'h300, 0);
        writeFrame(1, 'h310, 0);
        writeFrame(1, 'h320, 0);
        checkOutput("plan_drops", 1, dropped[1], 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkStatus(1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 1, i, 0);

        // Mid-frame SOF: partial frame abandoned, exactly one commit.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 1, 0, 'h2A0 + i, 0, 0, 0);
            checkStatus(1);
        end
        writeFrame(1, 'h200, 0);
        checkOutput("midsof_drops", 1, dropped[1], 2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkStatus(1);

        // Commit and reader swap in the same cycle with a frame already pending.
        writeFrame(1, 'h400, 0);
        saved_drops = m_dropped[1];
        writeFrame(1, 'h500, 1);
        checkOutput("simul_ready", 1, frame_ready[1], 1);
        checkOutput("simul_drops", 1, dropped[1], saved_drops);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 1, i, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 5, 0);
        checkStatus(1);

        // Reset mid-frame, then pixels without SOF fill the frame from offset 0.
        repeat (LAT + 1) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, i == 0, 'h7A0 + i, 0, 0, 0);
        do_reset();
        checkReset();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(0, 1, 0, 'h600 + i, 0, 0, 0);
            checkStatus(0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 7, 0);
        checkStatus(0);

        runRandom(0, 300);
        runRandom(1, 300);

        repeat (LAT + 2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("sb_drain", 0, exp_q0.size(), 0);
        checkOutput("sb_drain", 1, exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
